vector_result_checker: RTL and testbench
========================================

// Module: vector_result_checker
// PURPOSE
//  Downstream consumer of the combinational dut stage. Each beat carries the 20-bit stimulus
//  applied to the dut, the dut's 10-bit response and the golden expected response.
//  The block compares response against golden under a per-bit mask and keeps vector and
//  error counts. Mismatch records are buffered in a FIFO for the bench/logger to drain.
// PARAMETERS
//  IN_W        20  stimulus width (matches dut input)
//  OUT_W       10  response width (matches dut output)
//  CNT_W       16  width of vec_count / err_count / record index
//  FIFO_DEPTH   4  mismatch-record FIFO entries; power of two, >=2
// PORTS
//  clk         in   1            single clock, rising edge
//  rst         in   1            synchronous, active-high reset
//  start       in   1            pulse: clear counters/FIFO, begin a run
//  s_valid     in   1            beat valid
//  s_ready     out  1            beat accepted when s_valid & s_ready
//  s_last      in   1            final beat of run
//  s_stim      in   IN_W         stimulus applied to dut
//  s_resp      in   OUT_W        dut response
//  s_exp       in   OUT_W        golden response
//  s_mask      in   OUT_W        1 = bit is checked
//  m_valid     out  1            mismatch record available
//  m_ready     in   1            record consumed when m_valid & m_ready
//  m_index     out  CNT_W        vector index of the record (0-based)
//  m_stim      out  IN_W         stimulus of failing vector
//  m_diff      out  OUT_W        (s_resp ^ s_exp) & s_mask
//  vec_count   out  CNT_W        beats accepted this run, saturating
//  err_count   out  CNT_W        failing beats this run, saturating
//  busy        out  1            state == RUN
//  done        out  1            state == DONE
//  pass        out  1            done & (err_count == 0)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; FIFO empty; counters 0.
//  FSM: IDLE --start--> RUN; RUN --accepted beat with s_last--> DONE;
//   DONE --start--> RUN. start in RUN restarts the run: counters and FIFO are cleared,
//   any beat offered in that cycle is not accepted, and state stays RUN.
//   start has priority over s_last.
//  s_ready = (state==RUN) & ~fifo_full & ~start. It does not depend on s_valid or data.
//   IDLE and DONE never accept.
//  Per accepted beat:
//   - diff = (s_resp ^ s_exp) & s_mask; fail = |diff.
//   - At the next edge, vec_count += 1 and err_count += fail. Both saturate at all-ones.
//   - The record index is the vec_count value before the increment.
//  Fail beat: at the same edge, {index, s_stim, diff} is pushed. m_valid rises the cycle
//   after the edge, so the record is visible one cycle after acceptance.
//  A full FIFO stalls all input via s_ready, even for passing beats. No record is dropped.
//  FIFO: first-word fall-through registered output; m_* stable while m_valid & ~m_ready.
//   Push and pop in the same cycle are legal, including when full: pop frees the slot,
//   but s_ready uses the pre-pop full flag.
//  FIFO drains in any state. done/pass hold until start or rst.
//  rst mid-run: everything returns to reset values on that edge; pending records are lost.
//  Mask 0 means that bit never fails. s_mask = 0 makes every beat pass.
// TESTING
//  1 Reset, start, 3 matching beats (s_exp=s_resp=10'b1000011010, mask=3FF, last on 3rd)
//    -> vec_count=3, err_count=0, done=1, pass=1, m_valid never high.
//  2 Beat 1 resp=10'b1000010001, exp=10'b1000010000 -> m_valid at accept+1,
//    m_index=1, m_diff=10'h001, err_count=1, pass=0 after last.
//  3 Same mismatch with mask=10'h3FE -> no record, err_count=0.
//  4 m_ready=0, 5 consecutive failing beats (depth 4) -> s_ready low after 4th push;
//    raise m_ready -> indices 0..3 drained in order, 5th accepted, index 4.
//  5 start asserted mid-run with 2 records queued -> FIFO empty, counters 0 next cycle,
//    beat offered with start not counted.
//  6 CNT_W=4, 20 failing beats with m_ready=1 -> vec_count=err_count=4'hF (saturated).

Source files
------------

// File: rtl/vector_result_checker.sv
// Checks dut responses against golden values under a per-bit mask, keeps saturating
// vector/error counts and queues mismatch records in a small fall-through FIFO.
module vector_result_checker #(
  parameter int unsigned IN_W       = 20,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic [IN_W-1:0]  s_stim,
  input  logic [OUT_W-1:0] s_resp,
  input  logic [OUT_W-1:0] s_exp,
  input  logic [OUT_W-1:0] s_mask,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_index,
  output logic [IN_W-1:0]  m_stim,
  output logic [OUT_W-1:0] m_diff,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned REC_W = CNT_W + IN_W + OUT_W;
  localparam logic [PTR_W:0] FullLvl = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fill_q;
  logic [CNT_W-1:0]   vec_q, err_q;
  logic [OUT_W-1:0]   diff;
  logic               fail, accept, push, pop, fifo_full;

  assign fifo_full = (fill_q == FullLvl);
  assign s_ready   = (state_q == StRun) & ~fifo_full & ~start;
  assign accept    = s_valid & s_ready;
  assign diff      = (s_resp ^ s_exp) & s_mask;
  assign fail      = |diff;
  assign push      = accept & fail;
  assign m_valid   = (fill_q != '0);
  assign pop       = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      // start suppresses accept, so a restart keeps the run alive
      StRun:   if (accept && s_last) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      vec_q <= '0;
      err_q <= '0;
    end else if (accept) begin
      if (vec_q != '1) vec_q <= vec_q + CNT_W'(1);
      if (fail && (err_q != '1)) err_q <= err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {vec_q, s_stim, diff};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + (PTR_W + 1)'(1);
        2'b01:   fill_q <= fill_q - (PTR_W + 1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign {m_index, m_stim, m_diff} = mem_q[rd_ptr_q];
  assign vec_count = vec_q;
  assign err_count = err_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign pass      = done & (err_q == '0);

endmodule

// File: tb/tb_vector_result_checker.sv
// Bench for vector_result_checker: directed scenarios plus random traffic checked
// against a queue-based behavioural model; a second narrow-counter instance covers saturation.
module tb_vector_result_checker;

  localparam int MAXC  = 65535;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [19:0] s_stim = '0;
  logic [9:0]  s_resp = '0, s_exp = '0, s_mask = '0;
  logic        s_ready, m_valid, busy, done, pass;
  logic [15:0] m_index, vec_count, err_count;
  logic [19:0] m_stim;
  logic [9:0]  m_diff;

  logic        b_rst = 1'b1, b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_m_ready = 1'b1;
  logic [19:0] b_stim = '0;
  logic [9:0]  b_resp = '0, b_exp = '0, b_mask = '0;
  logic        b_s_ready, b_m_valid, b_busy, b_done, b_pass;
  logic [3:0]  b_m_index, b_vec, b_err;
  logic [19:0] b_m_stim;
  logic [9:0]  b_m_diff;

  always #5 clk = ~clk;

  vector_result_checker #(.IN_W(20), .OUT_W(10), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_stim(s_stim), .s_resp(s_resp), .s_exp(s_exp), .s_mask(s_mask),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_stim(m_stim),
    .m_diff(m_diff), .vec_count(vec_count), .err_count(err_count), .busy(busy),
    .done(done), .pass(pass)
  );

  vector_result_checker #(.IN_W(20), .OUT_W(10), .CNT_W(4), .FIFO_DEPTH(4)) dut_sat (
    .clk(clk), .rst(b_rst), .start(b_start), .s_valid(b_valid), .s_ready(b_s_ready),
    .s_last(b_last), .s_stim(b_stim), .s_resp(b_resp), .s_exp(b_exp), .s_mask(b_mask),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_index(b_m_index), .m_stim(b_m_stim),
    .m_diff(b_m_diff), .vec_count(b_vec), .err_count(b_err), .busy(b_busy),
    .done(b_done), .pass(b_pass)
  );

  typedef struct {
    int          idx;
    logic [19:0] stim;
    logic [9:0]  diff;
  } rec_t;

  rec_t mq[$];
  int   mvec = 0, merr = 0;
  bit   mrun = 0, mdone = 0, last_acc = 0;
  int   ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    bit       exp_ready, acc, pp;
    logic [9:0] d;
    rec_t     r;
    #1;
    exp_ready = mrun && (mq.size() < DEPTH) && !start;
    chk("s_ready", 64'(s_ready), 64'(exp_ready));
    acc = s_valid && exp_ready;
    pp  = (mq.size() > 0) && m_ready;
    @(posedge clk);
    last_acc = 0;
    if (rst) begin
      mq.delete(); mvec = 0; merr = 0; mrun = 0; mdone = 0;
    end else if (start) begin
      mq.delete(); mvec = 0; merr = 0; mrun = 1; mdone = 0;
    end else begin
      if (pp) r = mq.pop_front();
      if (acc) begin
        last_acc = 1;
        d = (s_resp ^ s_exp) & s_mask;
        if (d != 0) begin
          mq.push_back('{mvec, s_stim, d});
          if (merr < MAXC) merr++;
        end
        if (mvec < MAXC) mvec++;
        if (s_last) begin mrun = 0; mdone = 1; end
      end
    end
    #1;
    chk("m_valid", 64'(m_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_index", 64'(m_index), 64'(16'(mq[0].idx)));
      chk("m_stim", 64'(m_stim), 64'(mq[0].stim));
      chk("m_diff", 64'(m_diff), 64'(mq[0].diff));
    end
    chk("vec_count", 64'(vec_count), 64'(16'(mvec)));
    chk("err_count", 64'(err_count), 64'(16'(merr)));
    chk("busy", 64'(busy), 64'(mrun));
    chk("done", 64'(done), 64'(mdone));
    chk("pass", 64'(pass), 64'(mdone && merr == 0));
  endtask

  task automatic send(input bit last, input logic [19:0] st, input logic [9:0] rs,
                      input logic [9:0] ex, input logic [9:0] mk);
    bit got = 0;
    s_valid = 1; s_last = last; s_stim = st; s_resp = rs; s_exp = ex; s_mask = mk;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = last_acc;
    end
    s_valid = 0; s_last = 0;
    chk("send_accepted", 64'(got), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  initial begin
    // Reset
    rst = 1; cycle(); cycle(); rst = 0; cycle();
    chk("rst_m_index", 64'(m_index), 64'd0);
    chk("rst_m_stim", 64'(m_stim), 64'd0);
    chk("rst_m_diff", 64'(m_diff), 64'd0);

    // 1: three matching beats
    pulse_start();
    for (int i = 0; i < 3; i++) send(i == 2, 20'(i), 10'b1000011010, 10'b1000011010, 10'h3FF);
    cycle();
    chk("t1_pass", 64'(pass), 64'd1);

    // 2: single-bit mismatch on beat 1
    pulse_start();
    send(0, 20'hA, 10'b1000011010, 10'b1000011010, 10'h3FF);
    send(1, 20'hB, 10'b1000010001, 10'b1000010000, 10'h3FF);
    chk("t2_index", 64'(m_index), 64'd1);
    chk("t2_diff", 64'(m_diff), 64'h001);
    repeat (2) cycle();

    // 3: same mismatch masked off
    pulse_start();
    send(1, 20'hC, 10'b1000010001, 10'b1000010000, 10'h3FE);
    cycle();

    // 4: stall on full FIFO, then drain
    m_ready = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) send(0, 20'(100 + i), 10'h3FF, 10'h000, 10'h3FF);
    s_valid = 1; s_stim = 20'd104;
    repeat (3) cycle();
    m_ready = 1;
    send(1, 20'd104, 10'h3FF, 10'h000, 10'h3FF);
    repeat (6) cycle();

    // 5: restart with records queued, beat offered alongside start
    m_ready = 0;
    pulse_start();
    send(0, 20'd1, 10'h001, 10'h000, 10'h3FF);
    send(0, 20'd2, 10'h002, 10'h000, 10'h3FF);
    s_valid = 1; s_resp = 10'h004; start = 1;
    cycle();
    start = 0; s_valid = 0;
    cycle();
    chk("t5_vec", 64'(vec_count), 64'd0);
    m_ready = 1;
    send(1, 20'd3, 10'h000, 10'h000, 10'h3FF);

    // Random traffic, including occasional restarts and mid-run resets
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(199) == 0);
      start   = !rst && ((mrun ? $urandom_range(59) : $urandom_range(7)) == 0);
      s_valid = ($urandom_range(9) < 7);
      s_last  = ($urandom_range(19) == 0);
      s_stim  = 20'($urandom);
      s_exp   = 10'($urandom);
      s_resp  = s_exp ^ (($urandom_range(2) == 0) ? 10'($urandom) : 10'h000);
      s_mask  = ($urandom_range(3) == 0) ? 10'($urandom) : 10'h3FF;
      m_ready = ($urandom_range(9) < 5);
      cycle();
    end
    rst = 0; start = 0; s_valid = 0; m_ready = 1;
    repeat (6) cycle();

    // 6: 4-bit counters saturate
    @(posedge clk); #1;
    b_rst = 0; b_start = 1;
    @(posedge clk); #1;
    b_start = 0; b_valid = 1; b_resp = 10'h001; b_exp = 10'h000; b_mask = 10'h3FF;
    repeat (20) @(posedge clk);
    #1 b_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_vec_sat", 64'(b_vec), 64'hF);
    chk("t6_err_sat", 64'(b_err), 64'hF);
    chk("t6_busy", 64'(b_busy), 64'd1);
    chk("t6_drained", 64'(b_m_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
